// File: rtl/led_serial_rx.sv
`default_nettype none
// ============================================================================
// Module  : led_serial_rx
// Brief   : Byte receiver for a chip-selected SPI-like LED link, with framing checks.
// Revision: 1.0 - initial release
// ============================================================================
module led_serial_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       SysClk,
    input  logic       SysRst,
    input  logic       SCLKIn,
    input  logic       DINIn,
    input  logic [7:0] CSIn,
    input  logic       CLRIn,
    output logic [7:0] DataOut,
    output logic [2:0] AddrOut,
    output logic       ValidOut,
    output logic       ErrOut,
    output logic       ClearOut
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_dinSync;
    logic [SYNC_STAGES-1:0] r_clrSync;
    logic [SYNC_STAGES-1:0] r_primed;
    logic [7:0]             r_csSync [SYNC_STAGES];

    state_t                 r_state;
    logic                   r_armed;
    logic                   r_sclkPrev;
    logic [7:0]             r_shift;
    logic [3:0]             r_bitCnt;
    logic [TMO_W-1:0]       r_tmo;
    logic [7:0]             r_csFrame;
    logic [2:0]             r_addr;

    logic                   w_sclk;
    logic                   w_din;
    logic                   w_clr;
    logic [7:0]             w_cs;
    logic [7:0]             w_csLow;
    logic                   w_csAllHigh;
    logic                   w_oneLow;
    logic                   w_sclkRise;
    logic [2:0]             w_csIdx;

    assign w_sclk      = r_sclkSync[SYNC_STAGES-1];
    assign w_din       = r_dinSync[SYNC_STAGES-1];
    assign w_clr       = r_clrSync[SYNC_STAGES-1];
    assign w_cs        = r_csSync[SYNC_STAGES-1];
    assign w_csLow     = ~w_cs;
    assign w_csAllHigh = (w_csLow == 8'd0);
    assign w_oneLow    = !w_csAllHigh && ((w_csLow & (w_csLow - 8'd1)) == 8'd0);
    assign w_sclkRise  = w_sclk && !r_sclkPrev;
    assign ClearOut    = w_clr;

    always_comb begin
        w_csIdx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_csLow[i]) w_csIdx = 3'(i);
        end
    end

    // r_primed marks when the synchronizers hold real post-reset samples
    always_ff @(posedge SysClk or negedge SysRst) begin
        if (!SysRst) begin
            r_sclkSync <= '0;
            r_dinSync  <= '0;
            r_clrSync  <= '1;
            r_primed   <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_csSync[i] <= 8'hFF;
        end else begin
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], SCLKIn};
            r_dinSync  <= {r_dinSync[SYNC_STAGES-2:0], DINIn};
            r_clrSync  <= {r_clrSync[SYNC_STAGES-2:0], CLRIn};
            r_primed   <= {r_primed[SYNC_STAGES-2:0], 1'b1};
            r_csSync[0] <= CSIn;
            for (int i = 1; i < SYNC_STAGES; i++) r_csSync[i] <= r_csSync[i-1];
        end
    end

    always_ff @(posedge SysClk or negedge SysRst) begin
        if (!SysRst) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b0;
            r_sclkPrev <= 1'b0;
            r_shift    <= 8'd0;
            r_bitCnt   <= 4'd0;
            r_tmo      <= '0;
            r_csFrame  <= 8'hFF;
            r_addr     <= 3'd0;
            DataOut    <= 8'd0;
            AddrOut    <= 3'd0;
            ValidOut   <= 1'b0;
            ErrOut     <= 1'b0;
        end else begin
            r_sclkPrev <= w_sclk;
            ValidOut   <= 1'b0;
            ErrOut     <= 1'b0;
            if (!w_clr) begin
                r_state <= S_WAIT;
                DataOut <= 8'd0;
                AddrOut <= 3'd0;
            end else if (!r_armed) begin
                // A frame already running at reset release is skipped entirely
                if (&r_primed) begin
                    r_armed <= 1'b1;
                    if (!w_csAllHigh) r_state <= S_WAIT;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_oneLow) begin
                            r_csFrame <= w_cs;
                            r_addr    <= w_csIdx;
                            r_shift   <= 8'd0;
                            r_bitCnt  <= 4'd0;
                            r_tmo     <= '0;
                            r_state   <= S_SHIFT;
                        end else if (!w_csAllHigh) begin
                            ErrOut  <= 1'b1;
                            r_state <= S_WAIT;
                        end
                    end
                    S_SHIFT: begin
                        if (w_csAllHigh) begin
                            if (r_bitCnt == 4'd8) begin
                                DataOut  <= r_shift;
                                AddrOut  <= r_addr;
                                ValidOut <= 1'b1;
                            end else begin
                                ErrOut <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else if (w_cs != r_csFrame) begin
                            ErrOut  <= 1'b1;
                            r_state <= S_WAIT;
                        end else if (w_sclkRise) begin
                            if (r_bitCnt == 4'd8) begin
                                ErrOut  <= 1'b1;
                                r_state <= S_WAIT;
                            end else begin
                                r_shift  <= {r_shift[6:0], w_din};
                                r_bitCnt <= r_bitCnt + 4'd1;
                                r_tmo    <= '0;
                            end
                        end else if (r_tmo >= TMO_W'(TIMEOUT - 1)) begin
                            r_tmo   <= TMO_W'(TIMEOUT);
                            ErrOut  <= 1'b1;
                            r_state <= S_WAIT;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (w_csAllHigh) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
